fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, drives the word address into `InstructionMemory`, takes the combinational instruction back, and registers it with PC+4 into the IF/ID pipeline register. Handles hazard stall, branch/jump redirect and flush from the decode stage. It sits directly upstream of `InstructionMemory` and feeds the decode stage.

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_id_register.sv | 23 ++
 rtl/fetch_stage.sv | 74 +++++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Constants and types shared by the fetch stage, InstructionMemory and the decode stage.
package mips_pkg;

  localparam int          WORD_W           = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] pc_plus4;
    logic              vld;
  } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register with hold and flush; flush and reset load the same bubble value.
module if_id_register #(
  parameter int                DATA_W = 65,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Hold outranks flush so a stalled redirect leaves the register untouched.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= BUBBLE;
    end else if (!hold) begin
      q <= flush ? BUBBLE : d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, sequential/redirect next-PC, range check, and the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] NOP       = NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] im_address,
  input  logic [31:0] im_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam if_id_t      BUBBLE           = '{instruction: NOP, pc_plus4: 32'h0, vld: 1'b0};

  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic        in_range_p0;
  if_id_t      fetch_p0;
  if_id_t      if_id_p1;

  // Stage p0: current PC drives the memory; result is formed combinationally.
  assign im_address  = pc_p0;
  assign pc_plus4_p0 = pc_p0 + 32'd4;
  assign in_range_p0 = {2'b00, pc_p0[31:2]} < 32'(MEM_WORDS);

  always_comb begin
    fetch_p0             = BUBBLE;
    fetch_p0.pc_plus4    = pc_plus4_p0;
    fetch_p0.vld         = in_range_p0;
    fetch_p0.instruction = in_range_p0 ? im_instruction : NOP;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_p0       <= RESET_PC_ALIGNED;
      fetch_fault <= 1'b0;
    end else if (!stall) begin
      if (redirect) begin
        pc_p0 <= {redirect_target[31:2], 2'b00};
      end else begin
        pc_p0 <= pc_plus4_p0;
        if (!in_range_p0) fetch_fault <= 1'b1;
      end
    end
  end

  // Stage p1: IF/ID register toward decode.
  if_id_register #(
    .DATA_W ($bits(if_id_t)),
    .BUBBLE (BUBBLE)
  ) u_if_id (
    .clock   (clock),
    .reset_n (reset_n),
    .hold    (stall),
    .flush   (redirect),
    .d       (fetch_p0),
    .q       (if_id_p1)
  );

  assign if_id_instruction = if_id_p1.instruction;
  assign if_id_pc_plus4    = if_id_p1.pc_plus4;
  assign if_id_valid       = if_id_p1.vld;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a default-reset instance and a wrap-around reset instance.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n_a = 1'b0, stall_a = 1'b0, redirect_a = 1'b0;
  logic [31:0] target_a = 32'h0;
  logic        reset_n_b = 1'b0, stall_b = 1'b0, redirect_b = 1'b0;
  logic [31:0] target_b = 32'h0;

  logic [31:0] im_address_a, im_instruction_a, instr_a, pc4_a;
  logic        valid_a, fault_a;
  logic [31:0] im_address_b, im_instruction_b, instr_b, pc4_b;
  logic        valid_b, fault_b;

  logic [31:0] mem [64];

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2008_0001 + 32'(i);
  end

  assign im_instruction_a = mem[im_address_a[7:2]];
  assign im_instruction_b = mem[im_address_b[7:2]];

  fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_WORDS(64), .NOP(32'h0000_0000)) dut_a (
    .clock(clock), .reset_n(reset_n_a), .stall(stall_a), .redirect(redirect_a),
    .redirect_target(target_a), .im_address(im_address_a), .im_instruction(im_instruction_a),
    .if_id_instruction(instr_a), .if_id_pc_plus4(pc4_a), .if_id_valid(valid_a),
    .fetch_fault(fault_a));

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .MEM_WORDS(64), .NOP(32'h0000_0000)) dut_b (
    .clock(clock), .reset_n(reset_n_b), .stall(stall_b), .redirect(redirect_b),
    .redirect_target(target_b), .im_address(im_address_b), .im_instruction(im_instruction_b),
    .if_id_instruction(instr_b), .if_id_pc_plus4(pc4_b), .if_id_valid(valid_b),
    .fetch_fault(fault_b));

  typedef struct {
    bit          sel;
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        vld;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs before the edge and queue the state required after it.
  task automatic cyc(input bit sel, input string tag, input logic rn, input logic st,
                     input logic rd, input logic [31:0] tgt, input logic [31:0] pc,
                     input logic [31:0] ins, input logic [31:0] p4, input logic v,
                     input logic f);
    exp_t e;
    @(negedge clock);
    if (!sel) begin
      reset_n_a = rn; stall_a = st; redirect_a = rd; target_a = tgt;
    end else begin
      reset_n_b = rn; stall_b = st; redirect_b = rd; target_b = tgt;
    end
    e = '{sel, tag, pc, ins, p4, v, f};
    exp_q.push_back(e);
  endtask

  // Monitor: one edge after each queued vector, compare the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.sel) begin
          chk({e.tag, ".pc"},    im_address_a, e.pc);
          chk({e.tag, ".instr"}, instr_a,      e.instr);
          chk({e.tag, ".pc4"},   pc4_a,        e.pc4);
          chk({e.tag, ".valid"}, {31'h0, valid_a}, {31'h0, e.vld});
          chk({e.tag, ".fault"}, {31'h0, fault_a}, {31'h0, e.fault});
        end else begin
          chk({e.tag, ".pc"},    im_address_b, e.pc);
          chk({e.tag, ".instr"}, instr_b,      e.instr);
          chk({e.tag, ".pc4"},   pc4_b,        e.pc4);
          chk({e.tag, ".valid"}, {31'h0, valid_b}, {31'h0, e.vld});
          chk({e.tag, ".fault"}, {31'h0, fault_b}, {31'h0, e.fault});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors unchecked", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    //       sel tag        rn st rd target          pc             instr          pc4            v  f
    cyc(0, "reset0",      0, 0, 0, 32'h0,         32'h0000_0000, 32'h0,         32'h0,         0, 0);
    cyc(0, "reset1",      0, 0, 0, 32'h0,         32'h0000_0000, 32'h0,         32'h0,         0, 0);
    cyc(0, "seq0",        1, 0, 0, 32'h0,         32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1, 0);
    cyc(0, "seq1",        1, 0, 0, 32'h0,         32'h0000_0008, 32'h2008_0002, 32'h0000_0008, 1, 0);
    cyc(0, "stall0",      1, 1, 0, 32'h0,         32'h0000_0008, 32'h2008_0002, 32'h0000_0008, 1, 0);
    cyc(0, "stall1",      1, 1, 0, 32'h0,         32'h0000_0008, 32'h2008_0002, 32'h0000_0008, 1, 0);
    cyc(0, "stall2",      1, 1, 0, 32'h0,         32'h0000_0008, 32'h2008_0002, 32'h0000_0008, 1, 0);
    cyc(0, "resume",      1, 0, 0, 32'h0,         32'h0000_000C, 32'h2008_0003, 32'h0000_000C, 1, 0);
    cyc(0, "redir28",     1, 0, 1, 32'h0000_0028, 32'h0000_0028, 32'h0,         32'h0,         0, 0);
    cyc(0, "tgt28",       1, 0, 0, 32'h0,         32'h0000_002C, 32'h2008_000B, 32'h0000_002C, 1, 0);
    cyc(0, "seq2c",       1, 0, 0, 32'h0,         32'h0000_0030, 32'h2008_000C, 32'h0000_0030, 1, 0);
    cyc(0, "redir0c",     1, 0, 1, 32'h0000_000C, 32'h0000_000C, 32'h0,         32'h0,         0, 0);
    cyc(0, "to16",        1, 0, 0, 32'h0,         32'h0000_0010, 32'h2008_0004, 32'h0000_0010, 1, 0);
    cyc(0, "stallredir",  1, 1, 1, 32'h0000_0040, 32'h0000_0010, 32'h2008_0004, 32'h0000_0010, 1, 0);
    cyc(0, "redir40",     1, 0, 1, 32'h0000_0040, 32'h0000_0040, 32'h0,         32'h0,         0, 0);
    cyc(0, "tgt40",       1, 0, 0, 32'h0,         32'h0000_0044, 32'h2008_0011, 32'h0000_0044, 1, 0);
    cyc(0, "redir102",    1, 0, 1, 32'h0000_0102, 32'h0000_0100, 32'h0,         32'h0,         0, 0);
    cyc(0, "oor100",      1, 0, 0, 32'h0,         32'h0000_0104, 32'h0,         32'h0000_0104, 0, 1);
    cyc(0, "oor104",      1, 0, 0, 32'h0,         32'h0000_0108, 32'h0,         32'h0000_0108, 0, 1);
    cyc(0, "oorstall",    1, 1, 0, 32'h0,         32'h0000_0108, 32'h0,         32'h0000_0108, 0, 1);
    cyc(0, "redir0",      1, 0, 1, 32'h0000_0000, 32'h0000_0000, 32'h0,         32'h0,         0, 1);
    cyc(0, "sticky",      1, 0, 0, 32'h0,         32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1, 1);
    cyc(0, "midreset",    0, 0, 0, 32'h0,         32'h0000_0000, 32'h0,         32'h0,         0, 0);
    cyc(0, "postreset",   1, 0, 0, 32'h0,         32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1, 0);

    cyc(1, "wrapreset",   0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0,         32'h0,         0, 0);
    cyc(1, "wrapfetch",   1, 0, 0, 32'h0,         32'h0000_0000, 32'h0,         32'h0000_0000, 0, 1);
    cyc(1, "wrap0",       1, 0, 0, 32'h0,         32'h0000_0004, 32'h2008_0001, 32'h0000_0004, 1, 1);
    cyc(1, "wrap4",       1, 0, 0, 32'h0,         32'h0000_0008, 32'h2008_0002, 32'h0000_0008, 1, 1);

    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
